ctech_lib_handshake_tx_ctrl: RTL and testbench
==============================================

// Module: ctech_lib_handshake_tx_ctrl
// PURPOSE
//  Source-side controller for a 4-phase req/ack bus handshake crossing into an unrelated clock domain.
//  Accepts one WIDTH-bit word via valid/ready, holds it stable on data_o, and sequences req_o.
//  Sequencing is driven by ack_i, which is synchronised through a set-style double synchroniser.
//  Sits beside ctech_lib_doublesync_* cells at every multi-bit CDC boundary; the sink side is a separate block.
// PARAMETERS
//  WIDTH           8     payload width in bits (>=1)
//  TIMEOUT_CYCLES  1023  cycles waiting in REQ or WAIT_LO before timeout_err sets; 0 disables the check
//  CNT_W           $clog2(TIMEOUT_CYCLES+1) (min 1); localparam, not overridable
// PORTS
//  clk          in   1      source-domain clock
//  rst          in   1      asynchronous, active-high reset
//  in_valid     in   1      upstream word valid
//  in_ready     out  1      controller can accept a word this cycle
//  in_data      in   WIDTH  upstream word
//  req_o        out  1      handshake request to far domain; registered, glitch-free
//  data_o       out  WIDTH  held payload to far domain; registered
//  ack_i        in   1      far-domain acknowledge, asynchronous to clk
//  busy         out  1      transfer in flight (state != IDLE)
//  timeout_err  out  1      sticky: handshake stalled for TIMEOUT_CYCLES
//  err_clr      in   1      synchronous clear of timeout_err
// BEHAVIOUR
//  Reset (async assert, sync-to-clk deassert handled by reset tree):
//   req_o=0, data_o=0, timeout_err=0, busy=1, in_ready=0, state=WAIT_LO.
//   The ack synchroniser is SET on rst, so ack_s=1.
//   Reset therefore never issues a new req until ack_s is seen low, which is safe after a reset mid-transfer.
//  ack_s = ack_i after the 2-flop synchroniser (2-cycle latency).
//  States:
//   IDLE    -> REQ      on in_valid & in_ready. Same edge: data_o<=in_data, req_o<=1.
//   REQ     -> WAIT_LO  on ack_s==1. Same edge: req_o<=0.
//   WAIT_LO -> IDLE     on ack_s==0.
//   Encoding 2'b11 is unreachable; it decodes to WAIT_LO.
//  in_ready = (state==IDLE) & ~ack_s. It is combinational from flops only, with no in_valid path.
//   A stray ack_s=1 in IDLE stalls acceptance; it causes no error.
//  data_o is stable from the accept edge until the return to IDLE. It changes only on an accept.
//  Latency: accept at edge N gives req_o=1 after edge N.
//   ack_i rising before edge k gives ack_s=1 after edge k+1 and req_o=0 after edge k+2.
//   Minimum accept-to-accept spacing: 1 + 2 synchroniser stages on each ack edge, plus far-side delay.
//  Timeout counter (CNT_W bits):
//   Clears on every state transition and in IDLE; increments each cycle in REQ/WAIT_LO.
//   Saturates at TIMEOUT_CYCLES.
//   timeout_err<=1 on the edge where the count reaches TIMEOUT_CYCLES.
//   The FSM keeps waiting; there is no abort.
//   err_clr clears timeout_err. If a set and err_clr land in the same cycle, the set wins.
//   With TIMEOUT_CYCLES=0 the counter is tied to 0 and timeout_err stays 0.
//  Reset mid-transfer: req_o drops asynchronously and data_o goes to 0; the far side must drop ack.
// STRUCTURE
//  Package ctech_lib_handshake_pkg:
//   typedef enum logic [1:0] {HS_IDLE=2'b00, HS_REQ=2'b01, HS_WAIT_LO=2'b10} hs_state_e;
//   localparam int HS_SYNC_STAGES = 2.
//  One sub-module: ctech_lib_doublesync_set, WIDTH=1, .d(ack_i), .clk(clk), .set(rst), .o(ack_s).
//  No other instances; FSM, counter and payload register are inline.
// TESTING
//  1 Reset with ack_i=0, release -> 3rd edge after release: in_ready=1, busy=0, req_o=0.
//  2 in_data=8'hA5, in_valid for 1 cycle -> req_o=1 and data_o=A5 next cycle; in_ready=0.
//    Then ack_i=1 -> req_o=0 two edges later; ack_i=0 -> in_ready=1 two edges later.
//  3 TIMEOUT_CYCLES=15, hold ack_i=0 after accept -> timeout_err=1 exactly 15 edges after entering REQ.
//    Then err_clr -> 0. err_clr held on the setting edge -> timeout_err=1.
//  4 Assert rst while in REQ with ack_i=1 -> req_o=0 immediately.
//    After release, in_ready stays 0 until ack_i=0 plus 2 edges; no req_o pulse.
//  5 ack_i pulse in IDLE with in_valid=1 -> no accept while ack_s=1; word accepted once ack_s=0.
//  6 100 back-to-back words with a random far-side delay of 0-7 cycles -> every word seen once, in order.
//    data_o is never changed while req_o=1 or in WAIT_LO.

Source files
------------

// File: rtl/ctech_lib_handshake_pkg.sv
// rtl/ctech_lib_handshake_pkg.sv - shared types for the 4-phase req/ack handshake controllers
package ctech_lib_handshake_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'b00,
    HS_REQ     = 2'b01,
    HS_WAIT_LO = 2'b10
  } hs_state_e;

  localparam int HS_SYNC_STAGES = 2;

endpackage

// File: rtl/ctech_lib_doublesync_set.sv
// rtl/ctech_lib_doublesync_set.sv - multi-stage synchroniser whose flops preset to 1
// Presetting makes a reset look like "ack still high", so the source waits for a clean low first.
module ctech_lib_doublesync_set
  import ctech_lib_handshake_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             set,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] o
);

  logic [HS_SYNC_STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      stage <= '1;
    end else begin
      stage <= {stage[HS_SYNC_STAGES-2:0], d};
    end
  end

  assign o = stage[HS_SYNC_STAGES-1];

endmodule

// File: rtl/ctech_lib_handshake_tx_ctrl.sv
// rtl/ctech_lib_handshake_tx_ctrl.sv - source side of a 4-phase req/ack CDC handshake
// Holds one word on data_o while req_o is sequenced against the synchronised acknowledge.
module ctech_lib_handshake_tx_ctrl
  import ctech_lib_handshake_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SET = CNT_W'(TIMEOUT_CYCLES - 1);

  hs_state_e        state;
  logic             ack_s;
  logic             accept;
  logic             state_adv;
  logic             set_err;
  logic [CNT_W-1:0] cnt;

  ctech_lib_doublesync_set #(
    .WIDTH(1)
  ) u_ack_sync (
    .clk (clk),
    .set (rst),
    .d   (ack_i),
    .o   (ack_s)
  );

  assign in_ready = (state == HS_IDLE) && !ack_s;
  assign busy     = (state != HS_IDLE);
  assign accept   = in_valid && in_ready;

  // The unused 2'b11 encoding is treated exactly like WAIT_LO.
  always_comb begin
    state_adv = 1'b0;
    case (state)
      HS_IDLE: state_adv = accept;
      HS_REQ:  state_adv = ack_s;
      default: state_adv = !ack_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= HS_WAIT_LO;
      req_o  <= 1'b0;
      data_o <= '0;
    end else begin
      case (state)
        HS_IDLE: begin
          if (accept) begin
            state  <= HS_REQ;
            req_o  <= 1'b1;
            data_o <= in_data;
          end
        end
        HS_REQ: begin
          if (ack_s) begin
            state <= HS_WAIT_LO;
            req_o <= 1'b0;
          end
        end
        default: begin
          if (!ack_s) begin
            state <= HS_IDLE;
          end
        end
      endcase
    end
  end

  // Stall watchdog: fires once when a single waiting phase reaches TIMEOUT_CYCLES.
  assign set_err = TO_EN && busy && !state_adv && (cnt == CNT_SET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else if (!TO_EN) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (!busy || state_adv) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (set_err) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctech_lib_handshake_tx_ctrl.sv
// tb/tb_ctech_lib_handshake_tx_ctrl.sv - directed self-checking bench for the handshake source controller
module tb_ctech_lib_handshake_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       req_o;
  logic [7:0] data_o;
  logic       ack_i = 1'b0;
  logic       busy;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  integer n_cmp = 0;
  integer n_bad = 0;

  always #5 clk = ~clk;

  ctech_lib_handshake_tx_ctrl #(
    .WIDTH(8),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .req_o       (req_o),
    .data_o      (data_o),
    .ack_i       (ack_i),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] word_of(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Stimulus only: drives a full ack rise/fall and lets the FSM return to IDLE.
  task automatic finish_handshake();
    ack_i = 1'b1;
    repeat (3) tick();
    ack_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_i = 1'b0; in_valid = 1'b0;
    repeat (3) tick();
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL rst_req_o got=%b want=0", req_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL rst_data_o got=%h want=00", data_o); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy got=%b want=1", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err got=%b want=0", timeout_err); end
    rst = 1'b0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rel_edge2_in_ready got=%b want=0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_edge3_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rel_edge3_busy got=%b want=0", busy); end
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL rel_edge3_req_o got=%b want=0", req_o); end
  endtask

  task automatic test_single_word();
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'h00;
    n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL accept_req_o got=%b want=1", req_o); end
    n_cmp++; if (data_o !== 8'hA5) begin n_bad++; $display("FAIL accept_data_o got=%h want=a5", data_o); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL accept_in_ready got=%b want=0", in_ready); end
    ack_i = 1'b1;
    tick(); tick();
    n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL ack_edge1_req_o got=%b want=1", req_o); end
    tick();
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL ack_edge2_req_o got=%b want=0", req_o); end
    ack_i = 1'b0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL acklo_edge1_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (data_o !== 8'hA5) begin n_bad++; $display("FAIL waitlo_data_o got=%h want=a5", data_o); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL acklo_edge2_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_timeout();
    in_data = 8'hC3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_edge14 got=%b want=0", timeout_err); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_edge15 got=%b want=1", timeout_err); end
    n_cmp++; if (req_o !== 1'b1) begin n_bad++; $display("FAIL to_no_abort_req_o got=%b want=1", req_o); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_clr got=%b want=0", timeout_err); end
    repeat (3) tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_saturated_no_reset got=%b want=0", timeout_err); end
    finish_handshake();
    in_data = 8'h3C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_set_beats_clr got=%b want=1", timeout_err); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky got=%b want=1", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    finish_handshake();
  endtask

  task automatic test_reset_mid_transfer();
    in_data = 8'h96; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ack_i = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL midrst_req_o got=%b want=0", req_o); end
    n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL midrst_data_o got=%h want=00", data_o); end
    tick();
    rst = 1'b0;
    in_data = 8'h77; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (in_ready !== 1'b0 || req_o !== 1'b0) begin
        n_bad++; $display("FAIL postrst_hold[%0d] in_ready=%b req_o=%b want 0/0", i, in_ready, req_o);
      end
    end
    ack_i = 1'b0;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL postrst_edge1_in_ready got=%b want=0", in_ready); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL postrst_edge2_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL postrst_no_req got=%b want=0", req_o); end
    in_valid = 1'b0;
  endtask

  task automatic test_stray_ack();
    ack_i = 1'b1;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stray_in_ready got=%b want=0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stray_busy got=%b want=0", busy); end
    in_data = 8'h5A; in_valid = 1'b1; ack_i = 1'b0;
    tick();
    n_cmp++; if (req_o !== 1'b0) begin n_bad++; $display("FAIL stray_no_accept got=%b want=0", req_o); end
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stray_ready_back got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (req_o !== 1'b1 || data_o !== 8'h5A) begin
      n_bad++; $display("FAIL stray_accept req_o=%b data_o=%h want 1/5a", req_o, data_o);
    end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL stray_no_err got=%b want=0", timeout_err); end
    finish_handshake();
  endtask

  task automatic test_back_to_back();
    bit     done = 1'b0;
    integer got = 0;
    fork
      begin : producer
        for (int i = 0; i < 100 && !done; i++) begin
          int k = 0;
          in_data = word_of(i); in_valid = 1'b1;
          while (!in_ready && k < 100 && !done) begin tick(); k++; end
          if (!in_ready) begin
            n_cmp++; n_bad++; $display("FAIL b2b_accept_timeout word=%0d in_ready=%b want=1", i, in_ready);
            done = 1'b1;
          end else begin
            tick();
          end
        end
        in_valid = 1'b0;
      end
      begin : consumer
        for (int j = 0; j < 100 && !done; j++) begin
          int k = 0;
          while (req_o !== 1'b1 && k < 200) begin tick(); k++; end
          if (req_o !== 1'b1) begin
            n_cmp++; n_bad++; $display("FAIL b2b_req_timeout word=%0d req_o=%b want=1", j, req_o);
            done = 1'b1;
          end else begin
            repeat ($urandom_range(0, 7)) tick();
            n_cmp++; if (data_o !== word_of(j)) begin
              n_bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", j, data_o, word_of(j));
            end
            got++;
            ack_i = 1'b1;
            k = 0;
            while (req_o !== 1'b0 && k < 50) begin tick(); k++; end
            repeat ($urandom_range(0, 7)) tick();
            ack_i = 1'b0;
          end
        end
        done = 1'b1;
      end
      begin : monitor
        logic [7:0] prev_data = data_o;
        logic       prev_busy = busy;
        int         n = 0;
        while (!done && n < 20000) begin
          tick(); n++;
          if (prev_busy) begin
            n_cmp++; if (data_o !== prev_data) begin
              n_bad++; $display("FAIL b2b_data_stable got=%h want=%h", data_o, prev_data);
            end
          end
          prev_data = data_o; prev_busy = busy;
        end
      end
    join
    repeat (12) tick();
    n_cmp++; if (got !== 100) begin n_bad++; $display("FAIL b2b_count got=%0d want=100", got); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL b2b_no_timeout got=%b want=0", timeout_err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_end got=%b want=1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_timeout();
    test_reset_mid_transfer();
    test_stray_ack();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
